// File: rtl/isp_uart_pkg.sv
// Shared types and constants for the ISP-completion UART command receiver.
package isp_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    typedef enum logic [1:0] {
        P_SYNC,
        P_CMD,
        P_ARG,
        P_CHK
    } parse_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam logic [7:0] RESTART_CMD_DEF = 8'h52;
    localparam logic [7:0] RESTART_ARG_DEF = 8'h01;

    // Frame check byte: XOR of sync, command and argument.
    function automatic logic [7:0] frame_chk(input logic [7:0] sync_b,
                                             input logic [7:0] cmd_b,
                                             input logic [7:0] arg_b);
        return sync_b ^ cmd_b ^ arg_b;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver: 2-FF synchroniser, oversample tick generator, byte FSM.
module uart_rx_core
    import isp_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       tick_c,
    output logic       rx_idle_c
);

    localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic             sync1_q, rxs_q;
    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             ferr_q, ferr_d;

    assign tick_c      = (div_q == DIV_W'(BAUD_DIV - 1));
    assign rx_idle_c   = (state_q == IDLE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = ferr_q;

    // Next-state logic for tick divider, bit timing and byte FSM.
    always_comb begin
        state_d    = state_q;
        div_d      = tick_c ? '0 : div_q + DIV_W'(1);
        tcnt_d     = tcnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    div_d   = '0;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (tick_c) begin
                    if (tcnt_q == 4'(MID_SAMPLE - 1)) begin
                        tcnt_d  = '0;
                        bit_d   = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (tcnt_q == 4'(OVERSAMPLE - 1)) begin
                        tcnt_d  = '0;
                        shift_d = {rxs_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    if (tcnt_q == 4'(OVERSAMPLE - 1)) begin
                        tcnt_d = '0;
                        if (rxs_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; synchroniser resets to line-idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            div_q      <= '0;
            tcnt_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            state_q    <= state_d;
            div_q      <= div_d;
            tcnt_q     <= tcnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
        end
    end

endmodule

// File: rtl/isp_uart_cmd_rx.sv
// ISP command receiver: UART byte core plus SYNC/CMD/ARG/CHK frame parser.
module isp_uart_cmd_rx
    import isp_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = 27,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [7:0]  RESTART_CMD  = RESTART_CMD_DEF,
    parameter logic [7:0]  RESTART_ARG  = RESTART_ARG_DEF,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       FRAMING_ERR,
    output logic [7:0] CMD,
    output logic [7:0] ARG,
    output logic       CMD_VALID,
    output logic       CHKSUM_ERR,
    output logic       RESTART_REQ,
    output logic       BUSY
);

    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

    logic             tick_c, rx_idle_c;
    parse_state_e     p_q, p_d;
    logic [7:0]       cmd_r_q, cmd_r_d, arg_r_q, arg_r_d;
    logic [7:0]       cmd_q, cmd_d, arg_q, arg_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             chk_err_q, chk_err_d;
    logic             restart_q, restart_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    uart_rx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_core (
        .clk        (CLK),
        .rst        (RESET),
        .rxd        (RXD),
        .rx_data    (RX_DATA),
        .rx_valid   (RX_VALID),
        .framing_err(FRAMING_ERR),
        .tick_c     (tick_c),
        .rx_idle_c  (rx_idle_c)
    );

    assign CMD         = cmd_q;
    assign ARG         = arg_q;
    assign CMD_VALID   = cmd_valid_q;
    assign CHKSUM_ERR  = chk_err_q;
    assign RESTART_REQ = restart_q;
    assign BUSY        = !rx_idle_c || (p_q != P_SYNC);

    // Frame parser and inter-byte timeout; a received byte beats a coincident timeout.
    always_comb begin
        p_d         = p_q;
        cmd_r_d     = cmd_r_q;
        arg_r_d     = arg_r_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        cmd_valid_d = 1'b0;
        chk_err_d   = 1'b0;
        restart_d   = 1'b0;
        tmo_d       = tmo_q;
        if (RX_VALID) begin
            tmo_d = '0;
            case (p_q)
                P_SYNC: if (RX_DATA == SYNC_BYTE) p_d = P_CMD;
                P_CMD: begin
                    cmd_r_d = RX_DATA;
                    p_d     = P_ARG;
                end
                P_ARG: begin
                    arg_r_d = RX_DATA;
                    p_d     = P_CHK;
                end
                P_CHK: begin
                    if (RX_DATA == frame_chk(SYNC_BYTE, cmd_r_q, arg_r_q)) begin
                        cmd_d       = cmd_r_q;
                        arg_d       = arg_r_q;
                        cmd_valid_d = 1'b1;
                        restart_d   = (cmd_r_q == RESTART_CMD) && (arg_r_q == RESTART_ARG);
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    p_d = P_SYNC;
                end
                default: p_d = P_SYNC;
            endcase
        end else if (FRAMING_ERR) begin
            p_d   = P_SYNC;
            tmo_d = '0;
        end else if (p_q == P_SYNC) begin
            tmo_d = '0;
        end else if (rx_idle_c && tick_c) begin
            if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
                p_d   = P_SYNC;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // Parser state and registered frame outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p_q         <= P_SYNC;
            cmd_r_q     <= '0;
            arg_r_q     <= '0;
            cmd_q       <= '0;
            arg_q       <= '0;
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            restart_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            p_q         <= p_d;
            cmd_r_q     <= cmd_r_d;
            arg_r_q     <= arg_r_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            cmd_valid_q <= cmd_valid_d;
            chk_err_q   <= chk_err_d;
            restart_q   <= restart_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule
